// File: rtl/chaos_pkg.sv
// Shared constants and state encoding for the chaos S-box loader.
package chaos_pkg;
  localparam int SBOX_WIDTH = 8;
  localparam int SBOX_DEPTH = 1 << SBOX_WIDTH;
  localparam int EMIT_W     = SBOX_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_FALLBACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sbox_perm_loader_used_bitmap.sv
// One flag per S-box value: sync clear-all, single set port, two async read ports.
module used_bitmap
  import chaos_pkg::*;
#(
  parameter int W = SBOX_WIDTH,
  parameter int D = 1 << W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_set_en,
  input  logic [W-1:0] i_set_idx,
  input  logic [W-1:0] i_rd0_idx,
  input  logic [W-1:0] i_rd1_idx,
  output logic         o_rd0_used,
  output logic         o_rd1_used
);
  logic [D-1:0] r_used;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_used            <= '0;
    else if (i_clr)    r_used            <= '0;
    else if (i_set_en) r_used[i_set_idx] <= 1'b1;
  end

  assign o_rd0_used = r_used[i_rd0_idx];
  assign o_rd1_used = r_used[i_rd1_idx];
endmodule

// File: rtl/sbox_perm_loader.sv
// Builds a bijective S-box from a chaos byte stream, emitting one entry per unique byte;
// long duplicate streaks fall back to an ascending scan for the smallest unused value.
module sbox_perm_loader
  import chaos_pkg::*;
#(
  parameter int MAX_REJECT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  chaos_valid,
  input  logic [SBOX_WIDTH-1:0] chaos_data,
  output logic                  chaos_ready,
  output logic                  sbox_valid,
  output logic [SBOX_WIDTH-1:0] sbox_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           reject_cnt
);
  localparam logic [7:0]        MAX_REJ  = 8'(MAX_REJECT);
  localparam logic [EMIT_W-1:0] LAST_IDX = EMIT_W'(SBOX_DEPTH - 1);
  localparam logic [EMIT_W-1:0] ONE_E    = EMIT_W'(1);

  state_e                r_state;
  logic [EMIT_W-1:0]     r_emit_cnt;
  logic [EMIT_W-1:0]     r_scan_idx;
  logic [7:0]            r_streak;
  logic [15:0]           r_reject_cnt;
  logic                  r_sbox_valid;
  logic [SBOX_WIDTH-1:0] r_sbox_out;
  logic                  r_done;

  logic                  w_in_fill, w_in_fb, w_accept;
  logic                  w_chaos_used, w_scan_used;
  logic                  w_fill_new, w_fill_dup, w_fb_new;
  logic                  w_set_en, w_clr, w_last;
  logic [SBOX_WIDTH-1:0] w_set_idx;
  logic [7:0]            w_streak_inc;

  assign w_in_fill    = (r_state == ST_FILL);
  assign w_in_fb      = (r_state == ST_FALLBACK);
  assign w_accept     = w_in_fill && chaos_valid;
  assign w_fill_new   = w_accept && !w_chaos_used;
  assign w_fill_dup   = w_accept &&  w_chaos_used;
  // scan_idx[8] cannot rise while an unused value remains; it only guards the probe.
  assign w_fb_new     = w_in_fb && !r_scan_idx[SBOX_WIDTH] && !w_scan_used;
  assign w_set_en     = w_fill_new || w_fb_new;
  assign w_set_idx    = w_in_fill ? chaos_data : r_scan_idx[SBOX_WIDTH-1:0];
  assign w_clr        = (r_state == ST_IDLE) && start;
  assign w_last       = (r_emit_cnt == LAST_IDX);
  assign w_streak_inc = r_streak + 8'd1;

  used_bitmap #(.W(SBOX_WIDTH), .D(SBOX_DEPTH)) u_used (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_clr),
    .i_set_en   (w_set_en),
    .i_set_idx  (w_set_idx),
    .i_rd0_idx  (chaos_data),
    .i_rd1_idx  (r_scan_idx[SBOX_WIDTH-1:0]),
    .o_rd0_used (w_chaos_used),
    .o_rd1_used (w_scan_used)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_emit_cnt   <= '0;
      r_scan_idx   <= '0;
      r_streak     <= '0;
      r_reject_cnt <= '0;
      r_sbox_valid <= 1'b0;
      r_sbox_out   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_sbox_valid <= w_set_en;
      r_sbox_out   <= w_set_en ? w_set_idx : '0;
      r_done       <= w_set_en && w_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_emit_cnt   <= '0;
            r_scan_idx   <= '0;
            r_streak     <= '0;
            r_reject_cnt <= '0;
            r_state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_fill_new) begin
            r_emit_cnt <= r_emit_cnt + ONE_E;
            r_streak   <= '0;
            if (w_last) r_state <= ST_DONE;
          end else if (w_fill_dup) begin
            r_reject_cnt <= sat_inc16(r_reject_cnt);
            r_streak     <= w_streak_inc;
            if (w_streak_inc == MAX_REJ) r_state <= ST_FALLBACK;
          end
        end
        ST_FALLBACK: begin
          // Values below scan_idx are all used, so the scan never rewinds.
          r_scan_idx <= r_scan_idx + ONE_E;
          if (w_fb_new) begin
            r_emit_cnt <= r_emit_cnt + ONE_E;
            r_streak   <= '0;
            r_state    <= w_last ? ST_DONE : ST_FILL;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign chaos_ready = w_in_fill;
  assign busy        = w_in_fill || w_in_fb;
  assign sbox_valid  = r_sbox_valid;
  assign sbox_out    = r_sbox_out;
  assign done        = r_done;
  assign reject_cnt  = r_reject_cnt;
endmodule

// File: tb/tb_sbox_perm_loader.sv
// Bench for sbox_perm_loader: table of stream scenarios plus abort/restart sequences,
// every build checked against a value-level permutation model.
module tb_sbox_perm_loader;
  localparam int MAXR  = 64;
  localparam int SRC_N = 20000;
  localparam int MAXC  = 40000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        chaos_valid = 1'b0;
  logic [7:0]  chaos_data = 8'd0;
  logic        chaos_ready, sbox_valid, busy, done;
  logic [7:0]  sbox_out;
  logic [15:0] reject_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] src[SRC_N];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         exp_rej;
  int         done_cnt;

  typedef struct {
    string      nm;
    int         mode;
    int         gap;
    bit         hand;
    logic [7:0] e0, e1, e2;
    int         erej;
  } vec_t;
  vec_t vt[6];

  sbox_perm_loader #(.MAX_REJECT(MAXR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .chaos_valid (chaos_valid),
    .chaos_data  (chaos_data),
    .chaos_ready (chaos_ready),
    .sbox_valid  (sbox_valid),
    .sbox_out    (sbox_out),
    .busy        (busy),
    .done        (done),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < SRC_N; k++) begin
      case (mode)
        0:       src[k] = 8'(k);
        1:       src[k] = (k < 3) ? 8'd7 : (k == 3) ? 8'd9 : 8'(k);
        2:       src[k] = 8'h42;
        default: src[k] = 8'($urandom);
      endcase
    end
  endtask

  // Byte order alone decides the result: unique bytes are emitted, duplicates
  // counted, and after MAXR duplicates in a row the smallest unused value is taken.
  task automatic model();
    bit         used[256];
    int         streak, k;
    logic [7:0] b;
    exp_q.delete();
    exp_rej = 0; streak = 0; k = 0;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    while (exp_q.size() < 256 && k < SRC_N) begin
      if (streak == MAXR) begin
        for (int v = 0; v < 256; v++)
          if (!used[v]) begin used[v] = 1'b1; exp_q.push_back(8'(v)); break; end
        streak = 0;
      end else begin
        b = src[k]; k++;
        if (!used[b]) begin used[b] = 1'b1; exp_q.push_back(b); streak = 0; end
        else begin exp_rej++; streak++; end
      end
    end
    if (exp_rej > 65535) exp_rej = 65535;
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "/valid0"}, sbox_valid, 0);
    chk({nm, "/out0"},   sbox_out, 0);
    chk({nm, "/done0"},  done, 0);
    chk({nm, "/busy0"},  busy, 0);
    chk({nm, "/ready0"}, chaos_ready, 0);
    chk({nm, "/rej0"},   reject_cnt, 0);
  endtask

  task automatic run_build(input string nm, input int gap, input bit pulse_mid,
                           input bit pulse_done, input int abort_at, input bit chk_77);
    int idx, cyc, dups;
    bit hs, prev_ok, fin, v, aborted;
    bit seen[256];
    model();
    got.delete();
    done_cnt = 0; idx = 0; cyc = 0; fin = 0; prev_ok = 0; aborted = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "/rej_clr"}, reject_cnt, 0);
    chk({nm, "/busy"}, busy, 1);
    while (!fin && cyc < MAXC) begin
      case (gap)
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      chaos_valid = v;
      chaos_data  = src[idx];
      start       = pulse_mid && (cyc == 10);
      @(negedge clk);
      if (sbox_valid) begin
        chk({nm, "/valid_cause"}, prev_ok, 1);
        if (got.size() < 256) chk({nm, "/entry"}, sbox_out, exp_q[got.size()]);
        got.push_back(sbox_out);
        if (chk_77 && got.size() == 2) chk({nm, "/rej_after_9"}, reject_cnt, 2);
      end
      if (chk_77 && idx < 4) chk({nm, "/ready_held"}, chaos_ready, 1);
      if (done) begin
        done_cnt++;
        chk({nm, "/done_at_256"}, got.size(), 256);
        chk({nm, "/done_w_valid"}, sbox_valid, 1);
        fin = 1'b1;
        if (pulse_done) start = 1'b1;
      end
      if (abort_at > 0 && got.size() == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_outs_zero({nm, "/abort"});
        @(posedge clk); #1 reset_n = 1'b1;
        chaos_valid = 1'b0;
        aborted = 1'b1;
        break;
      end
      hs      = chaos_valid && chaos_ready;
      prev_ok = hs || (busy && !chaos_ready);
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
    end
    if (aborted) return;
    chaos_valid = 1'b0;
    chk({nm, "/finished"}, fin, 1);
    chk({nm, "/count"}, got.size(), 256);
    chk({nm, "/done_cnt"}, done_cnt, 1);
    chk({nm, "/rej_final"}, reject_cnt, exp_rej);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    dups = 0;
    foreach (got[i]) begin
      if (seen[got[i]]) dups++;
      seen[got[i]] = 1'b1;
    end
    chk({nm, "/perm_dups"}, dups, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({nm, "/idle_busy"}, busy, 0);
      chk({nm, "/idle_ready"}, chaos_ready, 0);
      chk({nm, "/idle_valid"}, sbox_valid, 0);
    end
  endtask

  initial begin
    vt[0] = '{"asc",     0, 0, 1'b1, 8'd0,  8'd1, 8'd2, 0};
    vt[1] = '{"dup7",    1, 0, 1'b1, 8'd7,  8'd9, 8'd4, 4};
    vt[2] = '{"const42", 2, 0, 1'b1, 8'h42, 8'd0, 8'd1, 255 * MAXR};
    vt[3] = '{"asc_gap", 0, 1, 1'b1, 8'd0,  8'd1, 8'd2, 0};
    vt[4] = '{"rnd",     3, 0, 1'b0, 8'd0,  8'd0, 8'd0, 0};
    vt[5] = '{"rnd_gap", 3, 2, 1'b0, 8'd0,  8'd0, 8'd0, 0};

    #1;
    chk_outs_zero("reset");
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk({"post_reset", "/busy"}, busy, 0);

    for (int t = 0; t < 6; t++) begin
      fill(vt[t].mode);
      run_build(vt[t].nm, vt[t].gap, 1'b0, 1'b0, 0, vt[t].mode == 1);
      if (vt[t].hand) begin
        chk({vt[t].nm, "/first0"}, got[0], vt[t].e0);
        chk({vt[t].nm, "/first1"}, got[1], vt[t].e1);
        chk({vt[t].nm, "/first2"}, got[2], vt[t].e2);
        chk({vt[t].nm, "/rej_hand"}, reject_cnt, vt[t].erej);
      end
    end

    // start during the build and together with done must both be ignored
    fill(3);
    run_build("start_pulses", 0, 1'b1, 1'b1, 0, 1'b0);
    fill(0);
    run_build("rebuild", 0, 1'b0, 1'b0, 0, 1'b0);

    // reset mid-build, then a clean build from scratch
    fill(3);
    run_build("abort", 0, 1'b0, 1'b0, 100, 1'b0);
    @(negedge clk);
    chk_outs_zero("after_abort");
    fill(3);
    run_build("after_rst", 2, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
